flag_cond_eval: RTL and testbench

- Read-side consumer of the 5-bit processor flags register.
- Takes a 4-bit condition code on a valid/ready request and snapshots the current flags.
- Evaluates the condition and returns a registered taken/not-taken result on a valid/ready response.
- Feeds branch/jump control. Keeps a saturating count of taken results for debug.

---
 rtl/flag_cond_eval.sv | 142 ++++++++++++++
 tb/tb_flag_cond_eval.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: evaluates a 4-bit condition code against a snapshot of the
// 5-bit processor flags (C,L,F,Z,N) and returns a registered taken result
// over a valid/ready response. It also keeps a saturating count of taken
// responses for debug.
//
// Build option: define FLAG_BYPASS_EN to forward a same-cycle flag write
// (flag_wr_en/flag_wr_data) into the snapshot at the request handshake.
// Without it, the snapshot always comes from flags_in.
module flag_cond_eval #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       flags_in,
  input  logic             flag_wr_en,
  input  logic [4:0]       flag_wr_data,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       cond,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Flag bit positions inside the 5-bit flags word.
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       cond_q;
  logic [4:0]       snap_q;
  logic             taken_q;
  logic [CNT_W-1:0] count_q;
  logic             req_fire;
  logic             resp_fire;
  logic [4:0]       snap_src;
  logic             eval_result;

  // Flag snapshot source: optionally forward a write landing this same cycle.
`ifdef FLAG_BYPASS_EN
  assign snap_src = flag_wr_en ? flag_wr_data : flags_in;
`else
  assign snap_src = flags_in;
`endif

  // State register; an asserted reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    req_fire   = 1'b0;
    resp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        req_fire  = req_valid;
        if (req_valid) state_d = EVAL;
      end
      EVAL: begin
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fire  = resp_ready;
        if (resp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Condition decode against the captured snapshot.
  always_comb begin
    eval_result = 1'b0;
    case (cond_q)
      4'd0:  eval_result =  snap_q[FLAG_Z];
      4'd1:  eval_result = !snap_q[FLAG_Z];
      4'd2:  eval_result =  snap_q[FLAG_C];
      4'd3:  eval_result = !snap_q[FLAG_C];
      4'd4:  eval_result =  snap_q[FLAG_L];
      4'd5:  eval_result = !snap_q[FLAG_L];
      4'd6:  eval_result =  snap_q[FLAG_N];
      4'd7:  eval_result = !snap_q[FLAG_N];
      4'd8:  eval_result =  snap_q[FLAG_F];
      4'd9:  eval_result = !snap_q[FLAG_F];
      4'd10: eval_result = !snap_q[FLAG_L] && !snap_q[FLAG_Z];
      4'd11: eval_result =  snap_q[FLAG_L] ||  snap_q[FLAG_Z];
      4'd12: eval_result = !snap_q[FLAG_N] && !snap_q[FLAG_Z];
      4'd13: eval_result =  snap_q[FLAG_N] ||  snap_q[FLAG_Z];
      4'd14: eval_result = 1'b1;
      4'd15: eval_result = 1'b0;
      default: eval_result = 1'b0;
    endcase
  end

  // Request capture, result register and saturating taken counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q  <= '0;
      snap_q  <= '0;
      taken_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (req_fire) begin
        cond_q <= cond;
        snap_q <= snap_src;
      end
      // taken only changes in EVAL, so it is stable for the whole RESP phase.
      if (state_q == EVAL) taken_q <= eval_result;
      if (resp_fire && taken_q && (count_q != CNT_MAX)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign taken       = taken_q;
  assign taken_count = count_q;

endmodule

// File: tb/tb_flag_cond_eval.sv
// tb_flag_cond_eval: directed scenarios with literal expectations, then a
// randomized phase, all checked every cycle against a transaction-level
// reference model (latency counter, table-driven condition predicate,
// saturating counter).
module tb_flag_cond_eval;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LAT     = 2;  // resp_valid appears this many cycles after acceptance

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       flags_in;
  logic             flag_wr_en;
  logic [4:0]       flag_wr_data;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       cond;
  logic             resp_valid;
  logic             resp_ready;
  logic             taken;
  logic [CNT_W-1:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;

  flag_cond_eval #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flags_in     (flags_in),
    .flag_wr_en   (flag_wr_en),
    .flag_wr_data (flag_wr_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .cond         (cond),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .taken        (taken),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition predicate: code>>1 picks a base predicate, code[0] inverts it,
  // except the compound codes 10..13 whose even member is the inverted one.
  function automatic logic ref_eval(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    logic [7:0] pred;
    logic inv;
    cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
    pred = {1'b1, nf | zf, lf | zf, ff, nf, lf, cf, zf};
    inv  = c[0] ^ ((c >= 4'd10) && (c <= 4'd13));
    return pred[c[3:1]] ^ inv;
  endfunction

  function automatic logic [4:0] ref_snapshot();
`ifdef FLAG_BYPASS_EN
    return flag_wr_en ? flag_wr_data : flags_in;
`else
    return flags_in;
`endif
  endfunction

  // Reference model: one transaction in flight at most.
  bit m_busy;
  int m_since;
  bit m_taken;
  int m_count;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_since <= 0;
      m_taken <= 1'b0;
      m_count <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_since <= 1;
        m_taken <= ref_eval(cond, ref_snapshot());
      end
    end else if (m_since >= LAT) begin
      if (resp_ready) begin
        m_busy <= 1'b0;
        if (m_taken && (m_count < CNT_MAX)) m_count <= m_count + 1;
      end
    end else begin
      m_since <= m_since + 1;
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_req_ready",  req_ready,  !m_busy);
      check("model_resp_valid", resp_valid, m_busy && (m_since >= LAT));
      if (m_busy && (m_since >= LAT)) check("model_taken", taken, m_taken);
      check("model_taken_count", taken_count, m_count);
    end
  end

  // Advance to the next drive/sample point (just after a falling edge).
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // One request with resp_ready held high; pins the result with a literal.
  task automatic run_req(input logic [3:0] c, input logic [4:0] f,
                         input logic exp_taken, input string name);
    int k;
    flags_in   = f;
    cond       = c;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    cyc();
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 8) begin
      cyc();
      k++;
    end
    check({name, "_resp_seen"}, resp_valid, 1);
    check({name, "_taken"}, taken, exp_taken);
    cyc();
  endtask

  initial begin
    static logic exp_cmp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset        = 1'b1;
    flags_in     = '0;
    flag_wr_en   = 1'b0;
    flag_wr_data = '0;
    req_valid    = 1'b0;
    cond         = '0;
    resp_ready   = 1'b0;
    cyc();
    cyc();
    check("rst_req_ready",   req_ready,   1);
    check("rst_resp_valid",  resp_valid,  0);
    check("rst_taken",       taken,       0);
    check("rst_taken_count", taken_count, 0);
    reset = 1'b0;
    cyc();

    // EQ with Z=1: result two cycles after acceptance.
    flags_in   = 5'b01000;
    cond       = 4'd0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    cyc();
    req_valid = 1'b0;
    check("eq_eval_not_valid", resp_valid, 0);
    check("eq_eval_not_ready", req_ready,  0);
    cyc();
    check("eq_resp_valid", resp_valid, 1);
    check("eq_taken",      taken,      1);
    cyc();
    check("eq_count",      taken_count, 1);
    check("eq_back_idle",  req_ready,   1);

    // Compound conditions with all flags clear.
    for (int i = 0; i < 4; i++) begin
      run_req(4'(10 + i), 5'b00000, exp_cmp[i], $sformatf("cmp%0d", 10 + i));
    end
    check("cmp_count", taken_count, 3);

    // Backpressure: result held while resp_ready is low.
    pulse_reset();
    cond       = 4'd14;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_taken",      taken,      1);
      check("bp_req_ready",  req_ready,  0);
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    check("bp_done_idle",  req_ready,   1);
    check("bp_done_valid", resp_valid,  0);
    check("bp_done_count", taken_count, 1);

    // Snapshot isolation: C drops during EVAL, result still uses C=1.
    flags_in  = 5'b00001;
    cond      = 4'd2;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    flags_in  = 5'b00000;
    cyc();
    check("snap_taken", taken, 1);
    cyc();

    // Same-cycle flag write at the handshake.
    flags_in     = 5'b00000;
    flag_wr_en   = 1'b1;
    flag_wr_data = 5'b01000;
    cond         = 4'd0;
    req_valid    = 1'b1;
    cyc();
    req_valid  = 1'b0;
    flag_wr_en = 1'b0;
    cyc();
`ifdef FLAG_BYPASS_EN
    check("bypass_taken", taken, 1);
`else
    check("bypass_taken", taken, 0);
`endif
    cyc();

    // Saturation: five UC requests into a 2-bit counter.
    pulse_reset();
    for (int i = 0; i < 5; i++) run_req(4'd14, 5'b00000, 1'b1, "sat");
    check("sat_count", taken_count, 3);

    // Asynchronous reset in the middle of a held response.
    cond       = 4'd14;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    check("mid_pre_valid", resp_valid, 1);
    check("mid_pre_taken", taken,      1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", resp_valid,  0);
    check("mid_rst_taken", taken,       0);
    check("mid_rst_ready", req_ready,   1);
    check("mid_rst_count", taken_count, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("mid_after_idle",  req_ready,  1);
    check("mid_after_valid", resp_valid, 0);

    // Randomized traffic, the per-cycle model compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      cond         = 4'($urandom_range(0, 15));
      flags_in     = 5'($urandom_range(0, 31));
      flag_wr_en   = ($urandom_range(0, 2) == 0);
      flag_wr_data = 5'($urandom_range(0, 31));
      resp_ready   = ($urandom_range(0, 9) < 7);
      reset        = ($urandom_range(0, 249) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
